seq_mult: RTL and testbench



---
 rtl/seq_mult.sv | 151 +++++++++++++++
 tb/tb_seq_mult.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// seq_mult: parametrised sequential shift-add multiplier with start/busy/done
// handshake and per-operation signed/unsigned mode. One partial product is
// accumulated per clock; the result is presented together with a one-cycle
// done pulse and held in p until the next result.
module seq_mult #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of an operand; the signed minimum maps to 2^(WIDTH-1), which
    // still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = ~v + WIDTH'(1'b1);
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic             neg_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [PW-1:0]    p_r;

    logic             load_s;
    logic             step_s;
    logic             finish_s;
    logic [PW-1:0]    pp_s;
    logic [PW-1:0]    acc_sum_s;
    logic [PW-1:0]    result_s;

    // Next-state decode and datapath control strobes.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (cnt_r == CW'(WIDTH - 1)) begin
                    next_state_s = DONE;
                    finish_s     = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                // A start here is accepted exactly as in IDLE (back-to-back).
                if (start) begin
                    next_state_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Partial product for the current multiplier bit and the final sign fix.
    // Negating zero yields zero, so no negative zero can appear.
    always_comb begin
        pp_s = {PW{1'b0}};
        if (mplier_r[cnt_r]) begin
            pp_s = {{WIDTH{1'b0}}, mcand_r} << cnt_r;
        end else begin
            pp_s = {PW{1'b0}};
        end
        acc_sum_s = acc_r + pp_s;
        if (neg_r) begin
            result_s = ~acc_sum_s + PW'(1'b1);
        end else begin
            result_s = acc_sum_s;
        end
    end

    // State, datapath and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            neg_r    <= 1'b0;
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            p_r      <= {PW{1'b0}};
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == RUN);
            done_r  <= (next_state_s == DONE);
            if (load_s) begin
                mcand_r  <= magnitude(a, signed_mode);
                mplier_r <= magnitude(b, signed_mode);
                neg_r    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc_r    <= {PW{1'b0}};
                cnt_r    <= {CW{1'b0}};
            end else if (step_s) begin
                acc_r <= acc_sum_s;
                cnt_r <= cnt_r + CW'(1'b1);
            end
            if (finish_s) begin
                p_r <= result_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: table-driven 6-bit vectors, hand-written
// back-to-back / ignored-start / reset-abort sequences, and a 16-bit
// randomised regression against an arithmetic reference model.
module tb_seq_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        busy;
    logic        done;
    logic [11:0] p;

    logic        start16;
    logic        mode16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;
    logic [11:0] prev_p;

    seq_mult #(.WIDTH(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .p(p)
    );

    seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(mode16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full operation on the 6-bit DUT with cycle-exact handshake checks.
    task automatic run_op(input logic mode, input logic [5:0] va, input logic [5:0] vb,
                          input logic [11:0] exp, input string name);
        start = 1'b1; signed_mode = mode; a = va; b = vb;
        tick();
        start = 1'b0; signed_mode = ~mode; a = ~va; b = ~vb;
        for (int i = 0; i < 6; i++) begin
            check({name, " busy"}, {63'd0, busy}, 64'd1);
            check({name, " done_low"}, {63'd0, done}, 64'd0);
            check({name, " p_hold"}, {52'd0, p}, {52'd0, prev_p});
            tick();
        end
        check({name, " done"}, {63'd0, done}, 64'd1);
        check({name, " busy_low"}, {63'd0, busy}, 64'd0);
        check({name, " p"}, {52'd0, p}, {52'd0, exp});
        prev_p = exp;
        tick();
        check({name, " done_pulse"}, {63'd0, done}, 64'd0);
        check({name, " p_after"}, {52'd0, p}, {52'd0, exp});
    endtask

    function automatic logic [31:0] ref16(input logic m, input logic [15:0] x, input logic [15:0] y);
        longint pr;
        if (m) begin
            pr = longint'($signed(x)) * longint'($signed(y));
        end else begin
            pr = longint'({16'd0, x}) * longint'({16'd0, y});
        end
        return pr[31:0];
    endfunction

    logic [15:0] ra[1000];
    logic [15:0] rb[1000];
    logic        rm[1000];

    initial begin
        vecs[0]  = '{1'b0, 6'd63, 6'd63, 12'hF81};
        vecs[1]  = '{1'b1, 6'h20, 6'h20, 12'h400};
        vecs[2]  = '{1'b1, 6'h20, 6'h01, 12'hFE0};
        vecs[3]  = '{1'b1, 6'h05, 6'h3D, 12'hFF1};
        vecs[4]  = '{1'b0, 6'd0,  6'd45, 12'h000};
        vecs[5]  = '{1'b1, 6'h3F, 6'h00, 12'h000};
        vecs[6]  = '{1'b0, 6'd10, 6'd20, 12'h0C8};
        vecs[7]  = '{1'b1, 6'h1F, 6'h1F, 12'h3C1};
        vecs[8]  = '{1'b1, 6'h20, 6'h1F, 12'hC20};
        vecs[9]  = '{1'b0, 6'd1,  6'd63, 12'h03F};
        vecs[10] = '{1'b1, 6'h3F, 6'h3F, 12'h001};
        vecs[11] = '{1'b0, 6'h20, 6'h20, 12'h400};

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = 6'd0; b = 6'd0;
        start16 = 1'b0; mode16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
        tick(); tick();
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset p", {52'd0, p}, 64'd0);
        rst = 1'b0;
        prev_p = 12'd0;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Back-to-back start in the done cycle, plus an ignored mid-RUN start.
        start = 1'b1; signed_mode = 1'b0; a = 6'd7; b = 6'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("b2b first done", {63'd0, done}, 64'd1);
        check("b2b first p", {52'd0, p}, 64'd63);
        start = 1'b1; a = 6'd2; b = 6'd3;
        tick();
        start = 1'b0; a = 6'd0; b = 6'd0;
        check("b2b second busy", {63'd0, busy}, 64'd1);
        check("b2b p held", {52'd0, p}, 64'd63);
        tick();
        start = 1'b1; a = 6'd5; b = 6'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("b2b second done", {63'd0, done}, 64'd1);
        check("b2b second p", {52'd0, p}, 64'd6);
        tick();
        check("midrun start dropped", {63'd0, busy}, 64'd0);
        check("midrun p held", {52'd0, p}, 64'd6);

        // Reset in the third RUN cycle of 10*20 aborts the operation.
        start = 1'b1; a = 6'd10; b = 6'd20;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort p", {52'd0, p}, 64'd0);
        prev_p = 12'd0;
        run_op(1'b0, 6'd10, 6'd20, 12'd200, "after_abort");

        // rst and start together: start is dropped.
        rst = 1'b1; start = 1'b1; a = 6'd3; b = 6'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start busy", {63'd0, busy}, 64'd0);
        tick();
        check("rst_start idle", {63'd0, busy}, 64'd0);
        check("rst_start p", {52'd0, p}, 64'd0);

        // 16-bit regression with continuous start.
        ra[0] = 16'h8000; rb[0] = 16'h8000; rm[0] = 1'b1;
        for (int i = 1; i < 1000; i++) begin
            ra[i] = 16'($urandom); rb[i] = 16'($urandom); rm[i] = 1'($urandom_range(1, 0));
        end
        start16 = 1'b1; mode16 = rm[0]; a16 = ra[0]; b16 = rb[0];
        tick();
        for (int k = 0; k < 1000; k++) begin
            int cyc;
            if (k < 999) begin
                mode16 = rm[k+1]; a16 = ra[k+1]; b16 = rb[k+1];
            end else begin
                start16 = 1'b0;
            end
            cyc = 1;
            while (!done16 && cyc < 40) begin
                tick();
                cyc++;
            end
            check($sformatf("w16 period %0d", k), 64'(cyc), 64'd17);
            check($sformatf("w16 p %0d", k), {32'd0, p16}, {32'd0, ref16(rm[k], ra[k], rb[k])});
            tick();
        end
        check("w16 idle", {63'd0, busy16}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
